stickman_motion: RTL
====================

STICKMAN_MOTION -- requirements
Module: stickman_motion

Interface
REQ-001 Parameter STICKMAN_X, default 120: stickman feet-centre x position (px).
REQ-002 Parameter INIT_Y, default 360: feet y after reset and in IDLE.
REQ-003 Parameter STICK_H, default 40: sprite height (px); also the minimum feet y.
REQ-004 Parameter STICK_HALF_W, default 8: sprite half-width (px).
REQ-005 Parameter JUMP_V, default 12: initial upward speed (px/frame).
REQ-006 Parameter GRAVITY, default 1: speed increment per frame.
REQ-007 Parameter MAX_FALL_V, default 15: downward speed clamp.
REQ-008 Parameter STEP_TOL, default 8: maximum step-up height climbable without collision.
REQ-009 Parameter SCREEN_YMAX, default 479: pitfall floor; GroundY at or above this means no floor.
REQ-010 Reset is Reset, synchronous, active-high; clock is Clk.
REQ-011 Ports:
- Clk  in  1  50 MHz clock
- Reset  in  1  synchronous active-high reset
- frame_clk  in  1  ~60 Hz frame clock
- playing  in  1  game running
- jump  in  1  jump key, level
- GroundY  in  10  floor height under the stickman, from the ground block
- DrawX, DrawY  in  10 each  current pixel
- StickY  out  10  feet y
- is_stickman  out  1  current pixel is the sprite
- game_over  out  1  collision or fall
- state  out  2  FSM state

Function
REQ-012 Frame tick: a one-Clk pulse, registered, asserted one Clk after frame_clk is sampled rising. All motion updates occur only on a tick.
REQ-013 FSM states: IDLE=0, RUN=1, AIR=2, DEAD=3.
REQ-014 In any state, playing=0 forces IDLE on the next Clk, with StickY=INIT_Y, vel=0 and game_over=0.
REQ-015 IDLE goes to RUN on the first Clk with playing=1; no tick is required.
REQ-016 RUN, on a tick, evaluates the following in priority order:
- jump=1 -> AIR, vel=-JUMP_V
- GroundY>StickY -> AIR, vel=0
- StickY-GroundY in 1..STEP_TOL -> StickY=GroundY, stay in RUN
- StickY-GroundY>STEP_TOL -> DEAD
- otherwise hold
REQ-017 AIR, on a tick:
- Compute y=StickY+vel in 11-bit signed.
- Then vel=min(vel+GRAVITY, MAX_FALL_V).
- vel is 6-bit signed.
REQ-018 AIR checks, in priority order:
- y>=SCREEN_YMAX -> DEAD, StickY=SCREEN_YMAX
- GroundY<SCREEN_YMAX, vel>=0 before update, y>=GroundY, StickY<=GroundY+STEP_TOL -> land: StickY=GroundY, vel=0, RUN
- StickY>GroundY+STEP_TOL -> DEAD (side wall)
- y<STICK_H -> StickY=STICK_H, vel=0
- else StickY=y
REQ-019 DEAD holds StickY, and game_over=1 while in DEAD; only playing=0 or Reset leaves DEAD.
REQ-020 is_stickman (combinational) = DrawX in [STICKMAN_X-STICK_HALF_W, STICKMAN_X+STICK_HALF_W] and DrawY in [StickY-STICK_H, StickY-1].
REQ-021 A tick coinciding with playing 0->1 in IDLE is ignored.

Reset
REQ-022 Reset sets:
- state=IDLE
- StickY=INIT_Y
- vel=0
- game_over=0
- tick pipeline cleared
- jump history cleared
- double-jump flag cleared
REQ-023 Reset mid-AIR or mid-DEAD takes effect on the next Clk and overrides every other condition.

Configuration
REQ-024 Macro STICKMAN_DOUBLE_JUMP_EN, when defined:
- In AIR, a jump rising edge (jump sampled at successive ticks, 0->1) with the double-used flag clear sets vel=-JUMP_V and sets the flag.
- The flag clears on landing and in IDLE.
REQ-025 Without STICKMAN_DOUBLE_JUMP_EN, jump is ignored in AIR and no flag or jump history exists.

Structure
REQ-026 Package stickman_pkg holds the state enum typedef and the physics constants' default values.
REQ-027 Sub-module frame_tick, instantiated once, generates the tick of REQ-012.

Verification
REQ-028 Reset, playing=1, GroundY=360, 10 ticks -> state=RUN, StickY=360.
REQ-029 In RUN, jump=1 for 1 tick -> StickY 348, 337, ... 282 at tick 12; lands with StickY=360 and state=RUN at tick 25.
REQ-030 In RUN, GroundY 360->355 -> StickY=355 after that tick, state=RUN; GroundY 360->300 -> DEAD, game_over=1.
REQ-031 GroundY=479 in RUN -> AIR; falling reaches y>=479 -> DEAD, StickY=479.
REQ-032 playing dropped mid-AIR -> IDLE next Clk, StickY=360; with STICKMAN_DOUBLE_JUMP_EN, a second jump edge in AIR resets vel to -12 exactly once per airtime.

Source files
------------

// File: rtl/stickman_pkg.sv
// Shared FSM encoding, physics defaults and the fall-speed clamp for the stickman.
package stickman_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_AIR  = 2'd2,
      ST_DEAD = 2'd3
   } stickman_state_t;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_AIR  = ST_AIR;
   localparam logic [1:0] S_DEAD = ST_DEAD;

   localparam int DEF_STICKMAN_X   = 120;
   localparam int DEF_INIT_Y       = 360;
   localparam int DEF_STICK_H      = 40;
   localparam int DEF_STICK_HALF_W = 8;
   localparam int DEF_JUMP_V       = 12;
   localparam int DEF_GRAVITY      = 1;
   localparam int DEF_MAX_FALL_V   = 15;
   localparam int DEF_STEP_TOL     = 8;
   localparam int DEF_SCREEN_YMAX  = 479;

   // v is one bit wider than the velocity register so vel+GRAVITY cannot wrap.
   function automatic logic signed [5:0] clamp_fall(input logic signed [6:0] v,
                                                    input int vmax);
      logic signed [6:0] lim;
      lim = $signed(7'(vmax));
      return (v > lim) ? lim[5:0] : v[5:0];
   endfunction

endpackage

// File: rtl/stickman_frame_tick.sv
// Turns the slow frame clock into a registered one-Clk tick, one Clk after its rise is sampled.
module frame_tick
   import stickman_pkg::*;
(
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic tick
);

   logic frame_prev;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_prev <= 1'b0;
         tick       <= 1'b0;
      end else begin
         frame_prev <= frame_clk;
         tick       <= frame_clk & ~frame_prev;
      end
   end

endmodule

// File: rtl/stickman_motion.sv
// Stickman run/jump/fall FSM with floor following, step-up, wall and pit deaths.
// Optional STICKMAN_DOUBLE_JUMP_EN allows one extra jump per airtime.
module stickman_motion
   import stickman_pkg::*;
#(
   parameter int STICKMAN_X   = DEF_STICKMAN_X,
   parameter int INIT_Y       = DEF_INIT_Y,
   parameter int STICK_H      = DEF_STICK_H,
   parameter int STICK_HALF_W = DEF_STICK_HALF_W,
   parameter int JUMP_V       = DEF_JUMP_V,
   parameter int GRAVITY      = DEF_GRAVITY,
   parameter int MAX_FALL_V   = DEF_MAX_FALL_V,
   parameter int STEP_TOL     = DEF_STEP_TOL,
   parameter int SCREEN_YMAX  = DEF_SCREEN_YMAX
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       playing,
   input  logic       jump,
   input  logic [9:0] GroundY,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic [9:0] StickY,
   output logic       is_stickman,
   output logic       game_over,
   output logic [1:0] state
);

   localparam logic [9:0]         INIT_Y10   = 10'(INIT_Y);
   localparam logic [9:0]         YMAX10     = 10'(SCREEN_YMAX);
   localparam logic [9:0]         STICK_H10  = 10'(STICK_H);
   localparam logic [10:0]        TOL11      = 11'(STEP_TOL);
   localparam logic [10:0]        H11        = 11'(STICK_H);
   localparam logic [10:0]        X_LO       = 11'(STICKMAN_X - STICK_HALF_W);
   localparam logic [10:0]        X_HI       = 11'(STICKMAN_X + STICK_HALF_W);
   localparam logic signed [10:0] YMAX_S     = 11'(SCREEN_YMAX);
   localparam logic signed [10:0] STICK_H_S  = 11'(STICK_H);
   localparam logic signed [5:0]  JUMP_V_NEG = 6'(-JUMP_V);
   localparam logic signed [6:0]  GRAV7      = 7'(GRAVITY);

   logic              tick;
   logic [1:0]        state_q, state_n;
   logic [9:0]        stick_y, stick_n;
   logic signed [5:0] vel, vel_n;

   logic [10:0]        stick_w, ground_w, ground_tol, run_drop;
   logic signed [10:0] y_next;
   logic signed [6:0]  vel_inc;
   logic signed [5:0]  vel_fall;
   logic               air_pit, air_land, air_wall, air_ceil;
   logic               dj_fire;

   frame_tick u_frame_tick (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .tick      (tick)
   );

   assign stick_w    = {1'b0, stick_y};
   assign ground_w   = {1'b0, GroundY};
   assign ground_tol = ground_w + TOL11;
   assign run_drop   = stick_w - ground_w;

   // Position uses the pre-update velocity; gravity applies afterwards.
   assign y_next   = $signed(stick_w) + $signed({{5{vel[5]}}, vel});
   assign vel_inc  = $signed({vel[5], vel}) + GRAV7;
   assign vel_fall = clamp_fall(vel_inc, MAX_FALL_V);

   assign air_pit  = (y_next >= YMAX_S);
   assign air_land = (GroundY < YMAX10) && !vel[5] &&
                     (y_next >= $signed(ground_w)) && (stick_w <= ground_tol);
   assign air_wall = (stick_w > ground_tol);
   assign air_ceil = (y_next < STICK_H_S);

`ifdef STICKMAN_DOUBLE_JUMP_EN
   logic jump_prev, dj_used, dj_set, dj_clr;

   assign dj_fire = jump && !jump_prev && !dj_used;
   assign dj_clr  = !playing || (state_q == S_IDLE) ||
                    ((state_q == S_AIR) && tick && !air_pit && air_land);
   assign dj_set  = playing && (state_q == S_AIR) && tick && !air_pit && !air_land &&
                    !air_wall && !air_ceil && dj_fire;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         jump_prev <= 1'b0;
         dj_used   <= 1'b0;
      end else begin
         if (tick)
            jump_prev <= jump;
         if (dj_clr)
            dj_used <= 1'b0;
         else if (dj_set)
            dj_used <= 1'b1;
      end
   end
`else
   assign dj_fire = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      stick_n = stick_y;
      vel_n   = vel;
      if (!playing) begin
         state_n = S_IDLE;
         stick_n = INIT_Y10;
         vel_n   = '0;
      end else begin
         case (state_q)
            S_IDLE: state_n = S_RUN;
            S_RUN: begin
               if (tick) begin
                  if (jump) begin
                     state_n = S_AIR;
                     vel_n   = JUMP_V_NEG;
                  end else if (GroundY > stick_y) begin
                     state_n = S_AIR;
                     vel_n   = '0;
                  end else if ((run_drop != '0) && (run_drop <= TOL11)) begin
                     stick_n = GroundY;
                  end else if (run_drop > TOL11) begin
                     state_n = S_DEAD;
                  end
               end
            end
            S_AIR: begin
               if (tick) begin
                  if (air_pit) begin
                     state_n = S_DEAD;
                     stick_n = YMAX10;
                  end else if (air_land) begin
                     state_n = S_RUN;
                     stick_n = GroundY;
                     vel_n   = '0;
                  end else if (air_wall) begin
                     state_n = S_DEAD;
                  end else if (air_ceil) begin
                     stick_n = STICK_H10;
                     vel_n   = '0;
                  end else begin
                     stick_n = y_next[9:0];
                     vel_n   = dj_fire ? JUMP_V_NEG : vel_fall;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         stick_y <= INIT_Y10;
         vel     <= '0;
      end else begin
         state_q <= state_n;
         stick_y <= stick_n;
         vel     <= vel_n;
      end
   end

   assign StickY    = stick_y;
   assign state     = state_q;
   assign game_over = (state_q == S_DEAD);

   assign is_stickman = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} <= X_HI) &&
                        ({1'b0, DrawY} >= stick_w - H11) && ({1'b0, DrawY} < stick_w);

endmodule
